// File: rtl/excp_trap_commit_if.sv
// ---------------------------------------------------------------------------
// excp_trap_commit_if
// Bundles the trap/debug/mret request side, the IFU flush handshake and the
// CSR write-pulse side of excp_trap_commit.
//   slave  : the trap committer (consumes requests, drives flush + CSR pulses)
//   master : the surrounding core (exception detector, IFU, CSR unit)
// Signals:
//   trap_req/dbg_req/mret_req  requests, held until trap_ack
//   trap_cause/pc/tval         trap information, sampled on accept
//   csr_mtvec/csr_mepc         current CSR values used to compute the target
//   trap_ack, busy             accept pulse / handler active
//   flush_req/flush_pc/flush_ack  IFU redirect handshake
//   *_we/*_wd, trap_enter, mret_exit, dbg_enter   one-cycle CSR unit pulses
// ---------------------------------------------------------------------------
interface excp_trap_commit_if #(
    parameter int XLEN = 32
);
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            dbg_req;
    logic            mret_req;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            trap_ack;
    logic            busy;
    logic            flush_req;
    logic [XLEN-1:0] flush_pc;
    logic            flush_ack;
    logic            mepc_we;
    logic [XLEN-1:0] mepc_wd;
    logic            mcause_we;
    logic [XLEN-1:0] mcause_wd;
    logic            mtval_we;
    logic [XLEN-1:0] mtval_wd;
    logic            trap_enter;
    logic            mret_exit;
    logic            dpc_we;
    logic [XLEN-1:0] dpc_wd;
    logic            dbg_enter;

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_tval, dbg_req, mret_req,
               csr_mtvec, csr_mepc, flush_ack,
        output trap_ack, busy, flush_req, flush_pc,
               mepc_we, mepc_wd, mcause_we, mcause_wd, mtval_we, mtval_wd,
               trap_enter, mret_exit, dpc_we, dpc_wd, dbg_enter
    );

    modport master (
        output trap_req, trap_cause, trap_pc, trap_tval, dbg_req, mret_req,
               csr_mtvec, csr_mepc, flush_ack,
        input  trap_ack, busy, flush_req, flush_pc,
               mepc_we, mepc_wd, mcause_we, mcause_wd, mtval_we, mtval_wd,
               trap_enter, mret_exit, dpc_we, dpc_wd, dbg_enter
    );
endinterface

// File: rtl/excp_trap_commit.sv
// ---------------------------------------------------------------------------
// excp_trap_commit
// Takes one trap / debug-entry / mret request at a time, redirects the IFU to
// the trap vector, debug entry or mepc through the flush handshake, then
// issues one-cycle CSR write pulses for that request.
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset; drops any in-flight request
//   bus  excp_trap_commit_if.slave (requests, flush handshake, CSR pulses)
// Flow: IDLE --accept--> FLUSH --flush_ack--> COMMIT (1 cycle) --> IDLE
// ---------------------------------------------------------------------------
module excp_trap_commit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] DBG_ENTRY = XLEN'(32'h0000_0800)
) (
    input  logic               clk,
    input  logic               rst,
    excp_trap_commit_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT} state_e;
    typedef enum logic [1:0] {K_TRAP, K_DBG, K_MRET}     kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q,  kind_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] tval_q,  tval_d;
    logic [XLEN-1:0] tgt_q,   tgt_d;

    logic            any_req;
    logic            accept;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] mtval_sel;

    assign any_req = bus.dbg_req | bus.trap_req | bus.mret_req;
    // No accept during reset: the acked request would be dropped by the
    // reset edge while the requester already believes it was taken.
    assign accept  = (state_q == S_IDLE) && any_req && !rst;

    // Vectored mode only offsets interrupts; exceptions always go to base.
    assign trap_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};
    assign trap_tgt  = (bus.csr_mtvec[1:0] == 2'b01 && bus.trap_cause[XLEN-1])
                     ? trap_base + {{(XLEN-7){1'b0}}, bus.trap_cause[4:0], 2'b00}
                     : trap_base;

    // mtval: faulting address/instruction for causes 0-2 and 4-7,
    // the pc for breakpoint (3), zero for everything else incl. interrupts.
    assign mtval_sel = (cause_q == XLEN'(3)) ? pc_q
                     : (cause_q <  XLEN'(8)) ? tval_q
                     : '0;

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_TRAP;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic; request information is captured only on accept
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        tgt_d   = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FLUSH;
                    cause_d = bus.trap_cause;
                    pc_d    = bus.trap_pc;
                    tval_d  = bus.trap_tval;
                    // Priority dbg > trap > mret; losers stay asserted.
                    if (bus.dbg_req) begin
                        kind_d = K_DBG;
                        tgt_d  = DBG_ENTRY;
                    end else if (bus.trap_req) begin
                        kind_d = K_TRAP;
                        tgt_d  = trap_tgt;
                    end else begin
                        kind_d = K_MRET;
                        tgt_d  = bus.csr_mepc;
                    end
                end
            end
            S_FLUSH:  if (bus.flush_ack) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.trap_ack   = accept;
        bus.busy       = (state_q != S_IDLE);
        bus.flush_req  = 1'b0;
        bus.flush_pc   = '0;
        bus.mepc_we    = 1'b0;
        bus.mepc_wd    = '0;
        bus.mcause_we  = 1'b0;
        bus.mcause_wd  = '0;
        bus.mtval_we   = 1'b0;
        bus.mtval_wd   = '0;
        bus.trap_enter = 1'b0;
        bus.mret_exit  = 1'b0;
        bus.dpc_we     = 1'b0;
        bus.dpc_wd     = '0;
        bus.dbg_enter  = 1'b0;
        if (state_q == S_FLUSH) begin
            bus.flush_req = 1'b1;
            bus.flush_pc  = tgt_q;
        end
        if (state_q == S_COMMIT) begin
            case (kind_q)
                K_TRAP: begin
                    bus.mepc_we    = 1'b1;
                    bus.mepc_wd    = {pc_q[XLEN-1:1], 1'b0};
                    bus.mcause_we  = 1'b1;
                    bus.mcause_wd  = cause_q;
                    bus.mtval_we   = 1'b1;
                    bus.mtval_wd   = mtval_sel;
                    bus.trap_enter = 1'b1;
                end
                K_DBG: begin
                    bus.dpc_we    = 1'b1;
                    bus.dpc_wd    = pc_q;
                    bus.dbg_enter = 1'b1;
                end
                K_MRET:  bus.mret_exit = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_excp_trap_commit.sv
// Scoreboard bench: stimulus pushes expected flush targets and CSR commit
// records; a negedge monitor pops and compares whenever flush_req rises or
// any CSR pulse appears.
module tb_excp_trap_commit;

    typedef struct packed {
        logic        mepc_we;
        logic [31:0] mepc_wd;
        logic        mcause_we;
        logic [31:0] mcause_wd;
        logic        mtval_we;
        logic [31:0] mtval_wd;
        logic        trap_enter;
        logic        mret_exit;
        logic        dpc_we;
        logic [31:0] dpc_wd;
        logic        dbg_enter;
    } cm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_flush_q [$];
    cm_t         exp_cm_q    [$];

    excp_trap_commit_if #(.XLEN(32)) bus ();

    excp_trap_commit #(.XLEN(32), .DBG_ENTRY(32'h0000_0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic cm_t cm_now();
        cm_t c;
        c.mepc_we    = bus.mepc_we;    c.mepc_wd   = bus.mepc_wd;
        c.mcause_we  = bus.mcause_we;  c.mcause_wd = bus.mcause_wd;
        c.mtval_we   = bus.mtval_we;   c.mtval_wd  = bus.mtval_wd;
        c.trap_enter = bus.trap_enter; c.mret_exit = bus.mret_exit;
        c.dpc_we     = bus.dpc_we;     c.dpc_wd    = bus.dpc_wd;
        c.dbg_enter  = bus.dbg_enter;
        return c;
    endfunction

    function automatic logic [191:0] all_outs();
        return 192'({bus.trap_ack, bus.busy, bus.flush_req, bus.flush_pc, cm_now()});
    endfunction

    function automatic cm_t cm_trap(input logic [31:0] mepc, mcause, mtval);
        cm_t c = '0;
        c.mepc_we = 1'b1;   c.mepc_wd   = mepc;
        c.mcause_we = 1'b1; c.mcause_wd = mcause;
        c.mtval_we = 1'b1;  c.mtval_wd  = mtval;
        c.trap_enter = 1'b1;
        return c;
    endfunction

    function automatic cm_t cm_dbg(input logic [31:0] dpc);
        cm_t c = '0;
        c.dpc_we = 1'b1; c.dpc_wd = dpc; c.dbg_enter = 1'b1;
        return c;
    endfunction

    function automatic cm_t cm_mret();
        cm_t c = '0;
        c.mret_exit = 1'b1;
        return c;
    endfunction

    // ---------------- monitor ----------------
    logic prev_fr = 1'b0;
    always @(negedge clk) begin
        cm_t cur;
        cur = cm_now();
        if (bus.flush_req && !prev_fr) begin
            if (exp_flush_q.size() == 0) chk("unexpected_flush", 192'(bus.flush_pc), 192'(0) - 192'(1));
            else chk("flush_pc", 192'(bus.flush_pc), 192'(exp_flush_q.pop_front()));
        end
        prev_fr = bus.flush_req;
        if (cur.mepc_we | cur.mcause_we | cur.mtval_we | cur.trap_enter |
            cur.mret_exit | cur.dpc_we | cur.dbg_enter) begin
            if (exp_cm_q.size() == 0) chk("unexpected_commit", 192'(cur), 192'(0));
            else chk("commit_rec", 192'(cur), 192'(exp_cm_q.pop_front()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic d, t, m, input logic [31:0] cause, pc, tval, mtvec, mepc);
        bus.dbg_req = d; bus.trap_req = t; bus.mret_req = m;
        bus.trap_cause = cause; bus.trap_pc = pc; bus.trap_tval = tval;
        bus.csr_mtvec = mtvec; bus.csr_mepc = mepc;
    endtask

    task automatic wait_ack(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.trap_ack) got = 1'b1;
        end
        chk(nm, 192'(got), 192'(1));
    endtask

    // Called right after the negedge that saw trap_ack. Runs k FLUSH cycles
    // (flush_ack in the k-th), the COMMIT cycle, and ends at the negedge of
    // the following IDLE cycle, reporting whether trap_ack is up there.
    task automatic handshake(input int k, input logic [2:0] drop, output logic ack_after);
        next_cyc();
        if (drop[2]) bus.dbg_req  = 1'b0;
        if (drop[1]) bus.trap_req = 1'b0;
        if (drop[0]) bus.mret_req = 1'b0;
        for (int i = 1; i <= k; i++) begin
            if (i == k) bus.flush_ack = 1'b1;
            @(negedge clk);
            chk("flush_busy", 192'({bus.busy, bus.flush_req, bus.trap_ack}), 192'(3'b110));
            next_cyc();
        end
        bus.flush_ack = 1'b0;
        @(negedge clk);
        chk("commit_busy", 192'({bus.busy, bus.flush_req, bus.trap_ack}), 192'(3'b100));
        next_cyc();
        @(negedge clk);
        chk("back_idle", 192'(bus.busy), 192'(0));
        ack_after = bus.trap_ack;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic a;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 192'(0));
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", all_outs(), 192'(0));
        next_cyc();

        // 1: load misaligned, flush_ack on the 3rd FLUSH cycle
        set_req(0, 1, 0, 32'd4, 32'h100, 32'h203, 32'h400, 0);
        exp_flush_q.push_back(32'h400);
        exp_cm_q.push_back(cm_trap(32'h100, 32'd4, 32'h203));
        wait_ack("t1_ack");
        handshake(3, 3'b010, a);
        chk("t1_no_ack_after", 192'(a), 192'(0));
        next_cyc();

        // 2: vectored interrupt 7
        set_req(0, 1, 0, 32'h8000_0007, 32'h200, 32'h55, 32'h401, 0);
        exp_flush_q.push_back(32'h41C);
        exp_cm_q.push_back(cm_trap(32'h200, 32'h8000_0007, 32'h0));
        wait_ack("t2_ack");
        handshake(2, 3'b010, a);
        next_cyc();

        // 3: dbg and trap together; exception ignores vectored offset
        set_req(1, 1, 0, 32'd2, 32'h305, 32'h13, 32'h401, 0);
        exp_flush_q.push_back(32'h800);
        exp_cm_q.push_back(cm_dbg(32'h305));
        exp_flush_q.push_back(32'h400);
        exp_cm_q.push_back(cm_trap(32'h304, 32'd2, 32'h13));
        wait_ack("t3_dbg_ack");
        handshake(2, 3'b100, a);
        chk("t3_trap_ack_at_Tk2", 192'(a), 192'(1));
        handshake(1, 3'b010, a);
        chk("t3_no_extra_ack", 192'(a), 192'(0));
        next_cyc();

        // 4: mret, flush_ack in the first FLUSH cycle
        set_req(0, 0, 1, 0, 0, 0, 32'h400, 32'h1234);
        exp_flush_q.push_back(32'h1234);
        exp_cm_q.push_back(cm_mret());
        wait_ack("t4_ack");
        handshake(1, 3'b001, a);
        next_cyc();

        // 5: reset during FLUSH (flush_ack also high, must be ignored)
        set_req(0, 1, 0, 32'd3, 32'h88, 32'h99, 32'h500, 0);
        exp_flush_q.push_back(32'h500);
        wait_ack("t5_ack");
        next_cyc();
        bus.trap_req = 1'b0;
        @(negedge clk);
        chk("t5_in_flush", 192'(bus.flush_req), 192'(1));
        next_cyc();
        rst = 1'b1;
        bus.flush_ack = 1'b1;
        next_cyc();
        rst = 1'b0;
        bus.flush_ack = 1'b0;
        @(negedge clk);
        chk("t5_outs_after_rst", all_outs(), 192'(0));
        repeat (2) next_cyc();

        // 7: breakpoint committed normally after reset, mtval = pc
        set_req(0, 1, 0, 32'd3, 32'h88, 32'h99, 32'h500, 0);
        exp_flush_q.push_back(32'h500);
        exp_cm_q.push_back(cm_trap(32'h88, 32'd3, 32'h88));
        wait_ack("t7_ack");
        handshake(2, 3'b010, a);
        next_cyc();

        // 6: ecall held while busy -> taken twice, no ack while busy
        set_req(0, 1, 0, 32'd11, 32'h40, 32'h77, 32'h600, 0);
        exp_flush_q.push_back(32'h600);
        exp_cm_q.push_back(cm_trap(32'h40, 32'd11, 32'h0));
        exp_flush_q.push_back(32'h600);
        exp_cm_q.push_back(cm_trap(32'h40, 32'd11, 32'h0));
        wait_ack("t6_ack");
        handshake(2, 3'b000, a);
        chk("t6_second_ack", 192'(a), 192'(1));
        handshake(1, 3'b010, a);
        next_cyc();

        // 8: reserved interrupt 0x1F vectored + mret together (trap wins)
        set_req(0, 1, 1, 32'h8000_001F, 32'h10, 32'h5, 32'h401, 32'h2000);
        exp_flush_q.push_back(32'h47C);
        exp_cm_q.push_back(cm_trap(32'h10, 32'h8000_001F, 32'h0));
        exp_flush_q.push_back(32'h2000);
        exp_cm_q.push_back(cm_mret());
        wait_ack("t8_trap_ack");
        handshake(1, 3'b010, a);
        chk("t8_mret_ack", 192'(a), 192'(1));
        handshake(1, 3'b001, a);
        repeat (3) next_cyc();

        chk("flush_q_drained", 192'(exp_flush_q.size()), 192'(0));
        chk("commit_q_drained", 192'(exp_cm_q.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
